// File: rtl/muldiv_pkg.sv
// Shared types and sizes for the HI/LO multiply/divide unit.
package muldiv_pkg;
  localparam int WIDTH = 32;
  localparam int ITER  = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;
endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     opnd_i,
  output logic [2*WIDTH-1:0]   acc_o
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;
  logic           qbit;

  always_comb begin
    sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
    // Partial remainder after the left shift needs 33 bits to compare safely.
    rem  = acc_i[2*WIDTH-1:WIDTH-1];
    diff = rem - {1'b0, opnd_i};
    qbit = ~diff[WIDTH];
    if (is_div) begin
      acc_o = qbit ? {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1}
                   : {acc_i[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_o = acc_i[0] ? {sum, acc_i[WIDTH-1:1]}
                       : {1'b0, acc_i[2*WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: IDLE -> RUN (32 iterations) -> FIX (sign fixup, write HI/LO).
// Define MULDIV_FAST_MULT_EN to send multiplies through a single-cycle multiplier (IDLE -> FIX).
module hilo_muldiv
  import muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);
  localparam int CNT_W = $clog2(ITER);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, acc_step, acc_neg;
  logic [WIDTH-1:0]     opnd_q, opnd_d, rs_q, rs_d, hi_q, hi_d, lo_q, lo_d;
  logic                 is_div_q, is_div_d, res_neg_q, res_neg_d;
  logic                 rem_neg_q, rem_neg_d, dz_q, dz_d, done_q, done_d;

  op_e                  op_v;
  logic                 signed_v, div_v, rs_neg, rt_neg;
  logic [WIDTH-1:0]     rs_mag, rt_mag;

  assign op_v     = op_e'(op);
  assign signed_v = (op_v == OP_MULT) || (op_v == OP_DIV);
  assign div_v    = (op_v == OP_DIV)  || (op_v == OP_DIVU);
  assign rs_neg   = signed_v & rs[WIDTH-1];
  assign rt_neg   = signed_v & rt[WIDTH-1];
  assign rs_mag   = rs_neg ? -rs : rs;
  assign rt_mag   = rt_neg ? -rt : rt;
  assign acc_neg  = -acc_q;

  muldiv_step u_step (
    .is_div (is_div_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (acc_step)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    rs_d      = rs_q;
    is_div_d  = is_div_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          is_div_d  = div_v;
          res_neg_d = rs_neg ^ rt_neg;
          rem_neg_d = rs_neg;
          dz_d      = div_v && (rt == '0);
          rs_d      = rs;
          // Multiply: acc low half holds the multiplier, opnd the multiplicand.
          opnd_d    = div_v ? rt_mag : rs_mag;
          acc_d     = div_v ? {{WIDTH{1'b0}}, rs_mag} : {{WIDTH{1'b0}}, rt_mag};
`ifdef MULDIV_FAST_MULT_EN
          if (!div_v) begin
            state_d = S_FIX;
            acc_d   = {{WIDTH{1'b0}}, rs_mag} * {{WIDTH{1'b0}}, rt_mag};
          end
`endif
        end else begin
          if (mthi) hi_d = rs;
          if (mtlo) lo_d = rs;
        end
      end
      S_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = res_neg_q ? acc_neg[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          lo_d = res_neg_q ? acc_neg[WIDTH-1:0]       : acc_q[WIDTH-1:0];
        end else if (dz_q) begin
          hi_d = rs_q;
          lo_d = '1;
        end else begin
          lo_d = res_neg_q ? -acc_q[WIDTH-1:0]         : acc_q[WIDTH-1:0];
          hi_d = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH]   : acc_q[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      rs_q      <= '0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      rs_q      <= rs_d;
      is_div_q  <= is_div_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: results, latency, interference while busy, reset abort.
module tb_hilo_muldiv;
  logic        clk = 1'b0;
  logic        rst, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] rs, rt;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 33;
`endif
  localparam int DLAT = 33;

  always #5 clk = ~clk;

  hilo_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs(rs), .rt(rt),
    .mthi(mthi), .mtlo(mtlo), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Ends at the negedge after the accepting edge E0.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; rs = 32'h5A5A_5A5A; rt = 32'hA5A5_A5A5;
  endtask

  // Counts edges from the current negedge until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                     input int elat);
    int lat;
    launch(o, a, b);
    chk({tag, " busy"}, {31'b0, busy}, 32'd1);
    wait_done(lat);
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " hi"}, hi, ehi);
    chk({tag, " lo"}, lo, elo);
    chk({tag, " busy_end"}, {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk({tag, " done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'd0; rs = '0; rt = '0;
    repeat (2) @(negedge clk);
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    rst = 1'b1;

    // Move-to HI/LO, together and singly.
    rs = 32'h0000_1234; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mt both hi", hi, 32'h0000_1234);
    chk("mt both lo", lo, 32'h0000_1234);
    rs = 32'h0000_ABCD; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi hi", hi, 32'h0000_ABCD);
    chk("mthi lo", lo, 32'h0000_1234);

    run("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MLAT);
    run("mult -7x3", 2'd0, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MLAT);
    run("div -7/2",  2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DLAT);
    run("divu 100/7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, DLAT);
    run("divu 5/0",  2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DLAT);
    run("div ovf",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DLAT);

    // start + mthi at cycle 10 of a divide must be ignored.
    launch(2'd3, 32'd42, 32'd6);
    repeat (10) @(negedge clk);
    start = 1'b1; op = 2'd3; rs = 32'h0000_DEAD; rt = 32'd1; mthi = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("busy ign hi", hi, 32'h0);
    chk("busy ign busy", {31'b0, busy}, 32'd1);
    wait_done(lat);
    chk("busy ign latency", 32'(lat), 32'(DLAT - 11));
    chk("busy ign lo", lo, 32'd7);
    chk("busy ign hi end", hi, 32'd0);
    @(negedge clk);

    // Reset at cycle 20 of a divide; mthi/mtlo during reset are ignored.
    launch(2'd3, 32'd100, 32'd7);
    repeat (20) @(negedge clk);
    rst = 1'b0; mthi = 1'b1; mtlo = 1'b1; rs = 32'h1111_1111;
    @(negedge clk);
    rst = 1'b1; mthi = 1'b0; mtlo = 1'b0;
    chk("abort hi", hi, 32'h0);
    chk("abort lo", lo, 32'h0);
    chk("abort busy", {31'b0, busy}, 32'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort no done", 32'(seen), 32'd0);
    chk("abort lo held", lo, 32'h0);

    run("divu after rst", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, DLAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL have port start, input, 1: request a new multiply/divide when idle.
REQ-004 SHALL have port op, input, 2: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU; sampled with start.
REQ-005 SHALL have port rs, input, 32: dividend/multiplicand, from register-file rs read port; sampled with start.
REQ-006 SHALL have port rt, input, 32: divisor/multiplier, from register-file rt read port; sampled with start.
REQ-007 SHALL have ports mthi, mtlo, input, 1 each: load rs into HI/LO respectively.
REQ-008 SHALL have ports hi, lo, output, 32 each: architectural HI/LO registers, continuously driven.
REQ-009 SHALL have port busy, output, 1: operation in progress.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when HI/LO take a new result.

Function
REQ-011 SHALL use states IDLE, RUN, FIX; IDLE->RUN on start, RUN->FIX after 32 iterations, FIX->IDLE unconditionally.
REQ-012 SHALL accept start only in IDLE; start in RUN/FIX ignored, operands not re-sampled.
REQ-013 SHALL, for an edge E0 accepting start, hold busy=1 from after E0 through edge E33, then busy=0 and done=1 for exactly the cycle after E33.
REQ-014 SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) iteration per RUN cycle on 32-bit magnitudes with 64-bit accumulator.
REQ-015 SHALL, for signed ops, convert operands to magnitudes at E0 and apply sign correction in FIX: product sign = sign(rs) xor sign(rt); quotient sign = sign(rs) xor sign(rt); remainder sign = sign(rs).
REQ-016 SHALL write multiply results as HI = product[63:32], LO = product[31:0].
REQ-017 SHALL write divide results as LO = quotient, HI = remainder.
REQ-018 SHALL, on divide by zero, write LO = 32'hFFFF_FFFF and HI = rs, with standard latency.
REQ-019 SHALL, for DIV 32'h8000_0000 / 32'hFFFF_FFFF, write LO = 32'h8000_0000, HI = 0.
REQ-020 SHALL, in IDLE, load HI <= rs on mthi and LO <= rs on mtlo at the next edge; both may assert together.
REQ-021 SHALL ignore mthi/mtlo while busy, and when asserted together with an accepted start (start has priority).
REQ-022 SHALL hold hi/lo stable except in FIX or on an accepted mthi/mtlo.

Reset
REQ-023 SHALL, with rst=0 at a rising edge, set state IDLE, hi=0, lo=0, busy=0, done=0, clear iteration counter.
REQ-024 SHALL abandon any in-flight operation on reset with no HI/LO update and no done pulse.
REQ-025 SHALL ignore start, mthi, mtlo in any cycle where rst=0.

Configuration
REQ-026 SHALL support macro MULDIV_FAST_MULT_EN.
REQ-027 SHALL, with MULDIV_FAST_MULT_EN defined, route MULT/MULTU IDLE->FIX directly using a single-cycle 32x32 multiplier: busy after E0 only, done in the cycle after E1; divides unchanged.
REQ-028 SHALL, without MULDIV_FAST_MULT_EN, use the iterative path for all four ops (REQ-013 latency).

Structure
REQ-029 SHALL place op encoding enum, state enum, WIDTH=32 and ITER=32 in shared package muldiv_pkg.
REQ-030 SHALL implement one iteration step (shift, conditional add/subtract, quotient bit) in combinational sub-module muldiv_step, instantiated once.

Verification
REQ-031 SHALL cover MULTU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> HI=32'hFFFF_FFFE, LO=32'h0000_0001, done in cycle after E33.
REQ-032 SHALL cover MULT -7 x 3 -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB.
REQ-033 SHALL cover DIV -7 / 2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; DIVU 100/7 -> LO=14, HI=2.
REQ-034 SHALL cover DIVU 5/0 -> LO=32'hFFFF_FFFF, HI=5; DIV 32'h8000_0000 / -1 -> LO=32'h8000_0000, HI=0.
REQ-035 SHALL cover start and mthi while busy at cycle 10 -> ignored, original result lands at E33.
REQ-036 SHALL cover rst=0 at cycle 20 of a divide -> hi=lo=0, busy=0, no done pulse; next start completes normally.
